// File: rtl/dds_pkg.sv
// Shared defaults, sample typedefs and quadrant encoding for the multi-channel quarter-wave NCO.
package dds_pkg;

    localparam int unsigned NCH_DEF     = 4;
    localparam int unsigned PHASE_W_DEF = 24;
    localparam int unsigned LUT_AW_DEF  = 8;
    localparam int unsigned OUT_W_DEF   = 16;

    typedef logic        [PHASE_W_DEF-1:0] phase_t;
    typedef logic signed [OUT_W_DEF-1:0]   sample_t;
    typedef logic        [OUT_W_DEF-2:0]   lut_entry_t;

    // Top two phase bits select the quarter of the sine period.
    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_t;

endpackage

// File: rtl/dds_mc_quad_nco_lut.sv
// Quarter-wave sine RAM: one write port, two registered read ports, read-first.
module qw_sine_lut #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 15
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic [DW-1:0] rd_data_a,
    output logic [DW-1:0] rd_data_b
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Write and both reads share one edge; reads see the pre-write contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_a <= mem[rd_addr_a];
        rd_data_b <= mem[rd_addr_b];
    end

endmodule

// File: rtl/dds_mc_quad_nco.sv
// Time-multiplexed NCH-channel NCO sharing one writable quarter-wave sine table.
module dds_mc_quad_nco
    import dds_pkg::*;
#(
    parameter int unsigned NCH     = NCH_DEF,
    parameter int unsigned PHASE_W = PHASE_W_DEF,
    parameter int unsigned LUT_AW  = LUT_AW_DEF,
    parameter int unsigned OUT_W   = OUT_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     phase_clr,
    input  logic                     cfg_we,
    input  logic [$clog2(NCH)-1:0]   cfg_ch,
    input  logic [PHASE_W-1:0]       cfg_fcw,
    input  logic [PHASE_W-1:0]       cfg_offset,
    input  logic                     tbl_we,
    input  logic [LUT_AW-1:0]        tbl_addr,
    input  logic [OUT_W-2:0]         tbl_data,
    output logic signed [OUT_W-1:0]  sin_out,
    output logic signed [OUT_W-1:0]  cos_out,
    output logic [$clog2(NCH)-1:0]   out_ch,
    output logic                     out_valid,
    output logic                     frame_start
);

    localparam int unsigned CH_W = $clog2(NCH);

    logic [CH_W-1:0]    slot;
    logic               pending;
    logic [PHASE_W-1:0] acc     [NCH];
    logic [PHASE_W-1:0] act_fcw [NCH];
    logic [PHASE_W-1:0] act_off [NCH];
    logic [PHASE_W-1:0] sh_fcw  [NCH];
    logic [PHASE_W-1:0] sh_off  [NCH];

    logic               issue_c;
    logic               commit_c;
    logic [PHASE_W-1:0] cur_fcw_c;
    logic [PHASE_W-1:0] cur_off_c;
    logic [PHASE_W-1:0] phase_c;

    logic               s1_valid;
    logic [CH_W-1:0]    s1_ch;
    quad_t              s1_quad;
    logic [LUT_AW-1:0]  s1_addr;

    logic               s2_valid;
    logic [CH_W-1:0]    s2_ch;
    quad_t              s2_quad;
    logic [OUT_W-2:0]   lut_a;
    logic [OUT_W-2:0]   lut_b;

    logic [OUT_W-1:0]   ent_a_c;
    logic [OUT_W-1:0]   ent_b_c;
    logic [OUT_W-1:0]   sin_c;
    logic [OUT_W-1:0]   cos_c;

    // Issue decode: a commit slot uses the freshly copied shadow config immediately.
    always_comb begin
        issue_c   = run && !phase_clr;
        commit_c  = issue_c && (slot == '0) && pending;
        cur_fcw_c = commit_c ? sh_fcw[slot] : act_fcw[slot];
        cur_off_c = commit_c ? sh_off[slot] : act_off[slot];
        phase_c   = acc[slot] + cur_off_c;
    end

    // Accumulators, shadow/active config and the pending-commit flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NCH); i++) begin
                acc[i]     <= '0;
                act_fcw[i] <= '0;
                act_off[i] <= '0;
                sh_fcw[i]  <= '0;
                sh_off[i]  <= '0;
            end
            pending <= 1'b0;
        end else begin
            if (phase_clr) begin
                for (int i = 0; i < int'(NCH); i++) begin
                    acc[i] <= '0;
                end
            end else if (issue_c) begin
                acc[slot] <= acc[slot] + cur_fcw_c;
                if (commit_c) begin
                    for (int i = 0; i < int'(NCH); i++) begin
                        act_fcw[i] <= sh_fcw[i];
                        act_off[i] <= sh_off[i];
                    end
                end
            end
            if (cfg_we) begin
                sh_fcw[cfg_ch] <= cfg_fcw;
                sh_off[cfg_ch] <= cfg_offset;
                pending        <= 1'b1;
            end else if (commit_c) begin
                pending <= 1'b0;
            end
        end
    end

    // Slot counter walks the channels while running.
    always_ff @(posedge clk) begin
        if (reset || phase_clr) begin
            slot <= '0;
        end else if (run) begin
            slot <= slot + CH_W'(1);
        end
    end

    // S1: split the issued phase into quadrant and table address.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_quad  <= QUAD_0;
            s1_addr  <= '0;
        end else begin
            s1_valid <= issue_c;
            if (issue_c) begin
                s1_ch   <= slot;
                s1_quad <= quad_t'(phase_c[PHASE_W-1 -: 2]);
                s1_addr <= phase_c[PHASE_W-3 -: LUT_AW];
            end
        end
    end

    // S2: table read of the address and its mirror.
    qw_sine_lut #(
        .AW (LUT_AW),
        .DW (OUT_W - 1)
    ) u_lut (
        .clk       (clk),
        .we        (tbl_we),
        .wr_addr   (tbl_addr),
        .wr_data   (tbl_data),
        .rd_addr_a (s1_addr),
        .rd_addr_b (~s1_addr),
        .rd_data_a (lut_a),
        .rd_data_b (lut_b)
    );

    // S2 control shadows the table read.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_ch    <= '0;
            s2_quad  <= QUAD_0;
        end else begin
            s2_valid <= s1_valid && !phase_clr;
            s2_ch    <= s1_ch;
            s2_quad  <= s1_quad;
        end
    end

    // S3 select: quadrant picks which entry feeds sin/cos and the sign of each.
    always_comb begin
        ent_a_c = {1'b0, lut_a};
        ent_b_c = {1'b0, lut_b};
        sin_c   = ent_a_c;
        cos_c   = ent_b_c;
        case (s2_quad)
            QUAD_0: begin sin_c = ent_a_c;  cos_c = ent_b_c;  end
            QUAD_1: begin sin_c = ent_b_c;  cos_c = -ent_a_c; end
            QUAD_2: begin sin_c = -ent_a_c; cos_c = -ent_b_c; end
            QUAD_3: begin sin_c = -ent_b_c; cos_c = ent_a_c;  end
        endcase
    end

    // S3 output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sin_out     <= '0;
            cos_out     <= '0;
            out_ch      <= '0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            out_valid   <= s2_valid && !phase_clr;
            frame_start <= s2_valid && !phase_clr && (s2_ch == '0);
            if (s2_valid && !phase_clr) begin
                out_ch  <= s2_ch;
                sin_out <= $signed(sin_c);
                cos_out <= $signed(cos_c);
            end
        end
    end

endmodule
